// File: rtl/serial_frame_tx_pkg.sv
// serial_frame_tx_pkg
// Shared definitions for the serial frame transmitter:
//   - default frame geometry (data bits per frame, clocks per serial bit)
//   - transmitter state encoding (3 bits, IDLE=0 .. STOP=4)
//   - width helper used for the bit timer and bit index counters
package serial_frame_tx_pkg;

  localparam int unsigned DEFAULT_DATA_BITS    = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 4;

  // Encoding values are fixed so state dumps match the older design.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned width_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// bit_timer
// Free-running bit-period counter for the serial transmitter.  Counts
// 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
// Ports:
//   Clk   - clock, rising edge
//   Reset - synchronous active-high reset, forces count to 0
//   Clear - holds the count at 0 (used while the transmitter is idle)
//   Tick  - high on the last cycle of each serial bit
module bit_timer
  import serial_frame_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  output logic Tick
);

  localparam int unsigned   TW   = width_for(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count;

  // With CLKS_PER_BIT=1 the count sits at 0 and Tick stays high, so every
  // cycle is a bit boundary.
  assign Tick = (count == LAST);

  always_ff @(posedge Clk) begin
    if (Reset || Clear || Tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
// Parallel-in, serial-out frame transmitter.  A word accepted through the
// Ready/Load handshake is sent as: start bit (0), DATA_BITS data bits LSB
// first, optional even-parity bit, stop bit (1).  Each bit is held for
// CLKS_PER_BIT clocks.  All outputs are registered.
// Parameters:
//   DATA_BITS    - data bits per frame (1..16)
//   CLKS_PER_BIT - clocks per serial bit (1..255)
//   PARITY_EN    - 1 inserts an even-parity bit after the data bits
// Ports:
//   Clk   - clock, rising edge
//   Reset - synchronous active-high reset
//   Load  - send request, accepted only while Ready=1
//   Data  - word to send, sampled on the accepting edge
//   Ready - idle and able to accept Load
//   Busy  - frame on the line (inverse of Ready)
//   TxD   - serial line, idles high
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Load,
  input  logic [DATA_BITS-1:0] Data,
  output logic                 Ready,
  output logic                 Busy,
  output logic                 TxD
);

  localparam int unsigned   IW       = width_for(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  state_t               state;
  state_t               state_nx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_nx;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        idx_nx;
  logic                 parity;
  logic                 parity_nx;
  logic                 tx_nx;
  logic                 timer_clear;
  logic                 tick;

  // Holding the timer cleared in IDLE makes the first start-bit cycle
  // begin at count 0 right after the accepting edge.
  assign timer_clear = (state == ST_IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .Clk  (Clk),
    .Reset(Reset),
    .Clear(timer_clear),
    .Tick (tick)
  );

  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    idx_nx    = idx;
    parity_nx = parity;
    tx_nx     = 1'b1;

    unique case (state)
      ST_IDLE: begin
        if (Load) begin
          state_nx  = ST_START;
          shreg_nx  = Data;
          parity_nx = ^Data;
          idx_nx    = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_nx = ST_DATA;
          idx_nx   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_nx = shreg >> 1;
          if (idx == LAST_IDX) begin
            state_nx = PARITY_EN ? ST_PARITY : ST_STOP;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // TxD is registered from the next-state view so the line changes on the
    // same edge as the state, with no combinational path to the pin.
    unique case (state_nx)
      ST_START:  tx_nx = 1'b0;
      ST_DATA:   tx_nx = shreg_nx[0];
      ST_PARITY: tx_nx = parity_nx;
      default:   tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      idx    <= '0;
      parity <= 1'b0;
      TxD    <= 1'b1;
      Ready  <= 1'b1;
      Busy   <= 1'b0;
    end else begin
      state  <= state_nx;
      shreg  <= shreg_nx;
      idx    <= idx_nx;
      parity <= parity_nx;
      TxD    <= tx_nx;
      Ready  <= (state_nx == ST_IDLE);
      Busy   <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx
// Self-checking bench for serial_frame_tx.  Three instances cover the
// default geometry, parity enabled, and a 4-bit / 1-clock-per-bit build.
// Frame vectors come from a table with hand-computed parity and lengths;
// reset, back-to-back, ignored-load and reset/load corner cases are
// hand-written sequences.
module tb_serial_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       load0, load1, load2;
  logic [7:0] data0, data1;
  logic [3:0] data2;
  logic       rdy0, bsy0, tx0;
  logic       rdy1, bsy1, tx1;
  logic       rdy2, bsy2, tx2;

  serial_frame_tx dut0 (
    .Clk(clk), .Reset(rst), .Load(load0), .Data(data0),
    .Ready(rdy0), .Busy(bsy0), .TxD(tx0)
  );

  serial_frame_tx #(
    .DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)
  ) dut1 (
    .Clk(clk), .Reset(rst), .Load(load1), .Data(data1),
    .Ready(rdy1), .Busy(bsy1), .TxD(tx1)
  );

  serial_frame_tx #(
    .DATA_BITS(4), .CLKS_PER_BIT(1), .PARITY_EN(1'b0)
  ) dut2 (
    .Clk(clk), .Reset(rst), .Load(load2), .Data(data2),
    .Ready(rdy2), .Busy(bsy2), .TxD(tx2)
  );

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  logic cur_tx, cur_rdy, cur_bsy;

  always_comb begin
    cur_tx  = tx2;
    cur_rdy = rdy2;
    cur_bsy = bsy2;
    if (sel == 0) begin
      cur_tx = tx0; cur_rdy = rdy0; cur_bsy = bsy0;
    end else if (sel == 1) begin
      cur_tx = tx1; cur_rdy = rdy1; cur_bsy = bsy1;
    end
  end

  typedef struct {
    int          s;     // instance
    logic [15:0] d;     // word
    logic        pbit;  // expected parity bit (parity instance only)
    int          n;     // expected frame length in cycles
  } vec_t;

  vec_t vecs[8];

  function automatic int cfg_db(input int s);
    return (s == 2) ? 4 : 8;
  endfunction

  function automatic int cfg_cpb(input int s);
    return (s == 2) ? 1 : 4;
  endfunction

  function automatic bit cfg_pe(input int s);
    return (s == 1);
  endfunction

  function automatic logic exp_bit(input int s, input logic [15:0] d,
                                   input logic pbit, input int b);
    int db;
    db = cfg_db(s);
    if (b == 0) return 1'b0;
    if (b <= db) return d[b-1];
    if (cfg_pe(s) && b == db + 1) return pbit;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic ld, input logic [15:0] d);
    if (s == 0) begin
      load0 = ld; data0 = d[7:0];
    end else if (s == 1) begin
      load1 = ld; data1 = d[7:0];
    end else begin
      load2 = ld; data2 = d[3:0];
    end
  endtask

  task automatic set_load(input int s, input logic ld);
    if (s == 0) load0 = ld;
    else if (s == 1) load1 = ld;
    else load2 = ld;
  endtask

  // Present a word for one accepting edge; returns at the negedge of the
  // first start-bit cycle with Load dropped.
  task automatic start_frame(input int s, input logic [15:0] d);
    @(negedge clk);
    drive(s, 1'b1, d);
    @(negedge clk);
    drive(s, 1'b0, d);
  endtask

  // Called at the negedge of frame cycle 1; checks n cycles and returns at
  // the negedge of cycle n+1.  An optional input change is applied at
  // ev_cycle, and Load is dropped again at drop_cycle.
  task automatic frame_body(input int s, input logic [15:0] d,
                            input logic pbit, input int n, input string tag,
                            input int ev_cycle, input logic ev_load,
                            input logic [15:0] ev_data, input int drop_cycle);
    for (int c = 0; c < n; c++) begin
      if (c == ev_cycle) drive(s, ev_load, ev_data);
      if (c == drop_cycle) set_load(s, 1'b0);
      check($sformatf("%s txd c%0d", tag, c + 1), cur_tx,
            exp_bit(s, d, pbit, c / cfg_cpb(s)));
      check($sformatf("%s ready c%0d", tag, c + 1), cur_rdy, 0);
      check($sformatf("%s busy c%0d", tag, c + 1), cur_bsy, 1);
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " txd"}, cur_tx, 1);
    check({tag, " ready"}, cur_rdy, 1);
    check({tag, " busy"}, cur_bsy, 0);
  endtask

  initial begin
    vecs[0] = '{0, 16'h00A5, 1'b0, 40};
    vecs[1] = '{0, 16'h0000, 1'b0, 40};
    vecs[2] = '{0, 16'h00FF, 1'b0, 40};
    vecs[3] = '{1, 16'h00A5, 1'b0, 44};
    vecs[4] = '{1, 16'h0001, 1'b1, 44};
    vecs[5] = '{1, 16'h007F, 1'b1, 44};
    vecs[6] = '{2, 16'h0009, 1'b0, 6};
    vecs[7] = '{2, 16'h0006, 1'b0, 6};

    rst = 1'b1;
    drive(0, 1'b0, 16'h0);
    drive(1, 1'b0, 16'h0);
    drive(2, 1'b0, 16'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset release: all instances hold mark, Ready high.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("reset_idle c%0d", c),
            {tx0, rdy0, bsy0, tx1, rdy1, bsy1, tx2, rdy2, bsy2},
            9'b110_110_110);
    end

    // Table frames; Data is scrambled right after acceptance.
    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].s;
      start_frame(vecs[i].s, vecs[i].d);
      frame_body(vecs[i].s, vecs[i].d, vecs[i].pbit, vecs[i].n,
                 $sformatf("vec%0d", i), 1, 1'b0, ~vecs[i].d, -1);
      check_idle($sformatf("vec%0d ready_back", i));
    end

    // Back-to-back with Load held high; Data switches mid-frame.
    sel = 0;
    @(negedge clk);
    drive(0, 1'b1, 16'h003C);
    @(negedge clk);
    frame_body(0, 16'h003C, 1'b0, 40, "b2b1", 20, 1'b1, 16'h00C3, -1);
    check_idle("b2b gap");
    @(negedge clk);
    frame_body(0, 16'h00C3, 1'b0, 40, "b2b2", 0, 1'b0, 16'h00C3, -1);
    check_idle("b2b end");
    @(negedge clk);
    check_idle("b2b end+1");

    // Load while busy is ignored and not queued.
    start_frame(0, 16'h0081);
    frame_body(0, 16'h0081, 1'b0, 40, "ign", 10, 1'b1, 16'h0000, 11);
    for (int c = 0; c < 4; c++) begin
      check_idle($sformatf("ign after c%0d", c));
      @(negedge clk);
    end

    // Reset asserted on cycle 12 of an 8'hFF frame.
    start_frame(0, 16'h00FF);
    for (int c = 1; c <= 11; c++) begin
      check($sformatf("rst_mid txd c%0d", c), tx0, (c <= 4) ? 1'b0 : 1'b1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_mid after");
    @(negedge clk);
    check_idle("rst_mid idle");
    start_frame(0, 16'h005A);
    frame_body(0, 16'h005A, 1'b0, 40, "post_rst", -1, 1'b0, 16'h0, -1);
    check_idle("post_rst ready_back");

    // Reset and Load on the same edge: reset wins, word dropped.
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b1, 16'h0055);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 16'h0055);
    for (int c = 0; c < 3; c++) begin
      check_idle($sformatf("rst_load c%0d", c));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
